multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Multicycle sequencer for the RV32I core. Drives the enables of the PC register and the datapath
//   registers: IR, operand A/B, ALU-out and MDR. Drives the register-file write and the memory request.
//   Runs FETCH/DECODE/EXEC/MEM/WB per instruction. Updates the PC once per instruction, at retire.
// PARAMETERS
//   CNT_W     32  width of the performance counters
//   MAX_WAIT  0   max cycles mem_req may wait for mem_ready; 0 = unlimited
// PORTS
//   clk           in   1      clock, rising edge
//   reset         in   1      asynchronous, active-high; FSM -> FETCH, counters -> 0
//   opcode        in   7      IR[6:0], valid from DECODE onward
//   branch_taken  in   1      ALU compare result, valid in EXEC
//   mem_ready     in   1      memory accept/return strobe
//   mem_req       out  1      memory request (fetch or data)
//   mem_we        out  1      store write strobe, qualified by mem_req
//   mem_sel_data  out  1      0 = address is PC (fetch), 1 = address is ALU-out (data)
//   ir_en         out  1      load IR
//   opnd_en       out  1      load operand A/B registers
//   alu_out_en    out  1      load ALU-out register
//   mdr_en        out  1      load MDR
//   rf_we         out  1      register-file write
//   wb_sel        out  2      0 = ALU-out, 1 = MDR, 2 = PC+4
//   pc_en         out  1      PC register enable
//   pc_src        out  2      0 = PC+4, 1 = branch target, 2 = ALU-out (JAL/JALR)
//   instr_retired out  1      1-cycle pulse per completed instruction
//   halt          out  1      FSM in HALT
//   halt_cause    out  2      0 = none, 1 = ECALL/EBREAK, 2 = illegal opcode, 3 = memory timeout
//   cycle_cnt     out  CNT_W  cycles since reset (optional feature)
//   instret_cnt   out  CNT_W  retired instructions (optional feature)
// BEHAVIOUR
//   - State register updates on posedge clk; async reset -> FETCH.
//   - Outputs decode combinationally from state, opcode, mem_ready and branch_taken.
//   - All outputs are 0 while reset is high. After release, the first cycle is FETCH with mem_req=1.
//   - Memory handshake:
//     * mem_req stays high until mem_ready is sampled 1; the transfer completes on that edge.
//     * mem_ready is ignored while mem_req=0.
//     * mem_we and mem_sel_data are held stable for the whole request.
//   - FETCH: mem_req=1, mem_sel_data=0. On mem_ready: ir_en=1 -> DECODE.
//   - DECODE: opnd_en=1.
//     * SYSTEM (1110011) -> HALT, cause 1.
//     * Opcode not in {LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC} -> HALT, cause 2.
//     * Otherwise -> EXEC.
//   - EXEC: alu_out_en=1.
//     * BRANCH retires here: pc_en=1, pc_src = branch_taken ? 1 : 0 -> FETCH.
//     * LOAD/STORE -> MEM.
//     * All others -> WB.
//   - MEM: mem_req=1, mem_sel_data=1, mem_we = STORE.
//     * On mem_ready, LOAD: mdr_en=1 -> WB.
//     * On mem_ready, STORE: retire, pc_en=1, pc_src=0 -> FETCH.
//   - WB: rf_we=1, pc_en=1 -> FETCH.
//     * wb_sel: LOAD = 1, JAL/JALR = 2, else 0.
//     * pc_src: JAL/JALR = 2, else 0.
//   - Retire cycle (pc_en=1) asserts instr_retired=1. Exactly one retire per instruction.
//   - Minimum latency, zero-wait memory: BRANCH 3, ALU/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5 cycles.
//     Each mem_ready stall adds one cycle.
//   - Timeout (MAX_WAIT>0): a wait counter counts consecutive cycles with mem_req=1 and mem_ready=0.
//     * Reaching MAX_WAIT -> HALT, cause 3, with no enables asserted that cycle.
//     * The counter clears on every completed transfer.
//   - HALT: absorbing. All enables 0, halt=1, halt_cause held until reset.
//   - Reset mid-request: mem_req drops immediately (async). Any partial transfer is abandoned.
// CONFIGURATION
//   - Macro MULTICYCLE_CTRL_PERF_CNT_EN, when defined:
//     * cycle_cnt increments every cycle out of reset, except in HALT.
//     * instret_cnt increments on instr_retired.
//     * Both wrap from 2^CNT_W-1 to 0. Both clear on reset.
//   - When undefined: both ports exist and are tied to 0; no counter flops are inferred.
// STRUCTURE
//   - Shared include cpu_ctrl_defs.vh holds:
//     * state encodings FETCH/DECODE/EXEC/MEM/WB/HALT (3-bit)
//     * RV32I opcode constants
//     * PC_SRC_*, WB_SEL_* and HALT_* encodings
//   - Sub-module rv_opcode_class: combinational opcode -> one-hot class {load, store, alu, branch, jump, upper, system, illegal}.
//     Shared with the datapath immediate generator.
// TESTING
//   1. Reset pulse mid-MEM with mem_req=1 -> mem_req=0 within the same cycle; after release, FETCH with mem_req=1.
//   2. OP (0110011), zero-wait memory -> retire in cycle 4: rf_we=1, wb_sel=0, pc_src=0, instr_retired=1.
//   3. LOAD (0000011), data mem_ready delayed 2 cycles -> mdr_en on the 6th cycle; retire in cycle 7 with wb_sel=1.
//   4. BRANCH: branch_taken=1 -> cycle-3 retire with pc_src=1. branch_taken=0 -> pc_src=0. No rf_we in either case.
//   5. Opcode 1111111 -> HALT: halt_cause=2, all enables 0 for 10 further cycles, halt=1.
//   6. MAX_WAIT=4, mem_ready held 0 in FETCH -> HALT, cause 3, after 4 wait cycles.
//      With the macro defined, run 3 OPs then ECALL -> instret_cnt=3; cycle_cnt frozen in HALT.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: state, opcode,
// PC-source, write-back select and halt-cause encodings, plus the
// one-hot opcode class used by the control FSM and the datapath.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    PC_SRC_PC4    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_ALU    = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MDR = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_SYSTEM  = 2'd1,
    HALT_ILLEGAL = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_cause_t;

  typedef struct packed {
    logic load;
    logic store;
    logic alu;
    logic branch;
    logic jump;
    logic upper;
    logic system;
    logic illegal;
  } opc_class_t;

  // True for instructions that need a data-memory phase.
  function automatic logic is_mem_op(input opc_class_t c);
    return c.load | c.store;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_rv_opcode_class.sv
// Combinational RV32I opcode classifier: 7-bit opcode to a one-hot
// class. Anything outside the supported base set is flagged illegal.
module rv_opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opc_class_t opc_class
);

  // Decode the major opcode into exactly one class bit.
  always_comb begin
    opc_class = '0;
    unique case (opcode)
      OPC_LOAD:              opc_class.load    = 1'b1;
      OPC_STORE:             opc_class.store   = 1'b1;
      OPC_OP, OPC_OP_IMM:    opc_class.alu     = 1'b1;
      OPC_BRANCH:            opc_class.branch  = 1'b1;
      OPC_JAL, OPC_JALR:     opc_class.jump    = 1'b1;
      OPC_LUI, OPC_AUIPC:    opc_class.upper   = 1'b1;
      OPC_SYSTEM:            opc_class.system  = 1'b1;
      default:               opc_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB
// with one PC update per instruction at retire, an optional memory
// wait timeout (MAX_WAIT > 0) and a sticky HALT state.
// Optional performance counters: define MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             ir_en,
  output logic             opnd_en,
  output logic             alu_out_en,
  output logic             mdr_en,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             instr_retired,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t      state_q, state_d;
  halt_cause_t cause_q, cause_d;
  opc_class_t  cls;
  logic        req_phase;
  logic        timeout;

  rv_opcode_class u_opc_class (
    .opcode    (opcode),
    .opc_class (cls)
  );

  assign req_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);

  if (MAX_WAIT > 0) begin : g_wait
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q;

    // Count consecutive stalled request cycles; any other cycle clears it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wait_q <= '0;
      end else if (req_phase && !mem_ready) begin
        wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= '0;
      end
    end

    assign timeout = req_phase && !mem_ready &&
                     (wait_q == WAIT_W'(MAX_WAIT - 1));
  end else begin : g_nowait
    assign timeout = 1'b0;
  end

  // State and halt-cause registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cause_q <= HALT_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and output decode; everything is forced low during reset
  // so mem_req drops asynchronously when reset rises mid-request.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_en        = 1'b0;
    opnd_en      = 1'b0;
    alu_out_en   = 1'b0;
    mdr_en       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    pc_en        = 1'b0;
    pc_src       = PC_SRC_PC4;

    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (timeout) begin
          state_d = ST_HALT;
          cause_d = HALT_TIMEOUT;
        end else if (mem_ready) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opnd_en = 1'b1;
        if (cls.system) begin
          state_d = ST_HALT;
          cause_d = HALT_SYSTEM;
        end else if (cls.illegal ||
                     !(cls.load | cls.store | cls.alu | cls.branch |
                       cls.jump | cls.upper)) begin
          state_d = ST_HALT;
          cause_d = HALT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_out_en = 1'b1;
        if (cls.branch) begin
          pc_en   = 1'b1;
          pc_src  = branch_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
          state_d = ST_FETCH;
        end else if (is_mem_op(cls)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = cls.store;
        if (timeout) begin
          state_d = ST_HALT;
          cause_d = HALT_TIMEOUT;
        end else if (mem_ready) begin
          if (cls.store) begin
            pc_en   = 1'b1;
            pc_src  = PC_SRC_PC4;
            state_d = ST_FETCH;
          end else begin
            mdr_en  = 1'b1;
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        wb_sel  = cls.load ? WB_SEL_MDR : (cls.jump ? WB_SEL_PC4 : WB_SEL_ALU);
        pc_src  = cls.jump ? PC_SRC_ALU : PC_SRC_PC4;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
        cause_d = HALT_ILLEGAL;
      end
    endcase

    instr_retired = pc_en;
    halt          = (state_q == ST_HALT);
    halt_cause    = cause_q;

    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_sel_data  = 1'b0;
      ir_en         = 1'b0;
      opnd_en       = 1'b0;
      alu_out_en    = 1'b0;
      mdr_en        = 1'b0;
      rf_we         = 1'b0;
      wb_sel        = '0;
      pc_en         = 1'b0;
      pc_src        = '0;
      instr_retired = 1'b0;
      halt          = 1'b0;
      halt_cause    = '0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  // Free-running cycle and retired-instruction counters, frozen in HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != ST_HALT) cycle_q <= cycle_q + CNT_W'(1);
      if (instr_retired)      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction is expanded
// into a per-cycle plan of required outputs and stimulus; random opcode
// mix, random memory stalls and random don't-care inputs.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  localparam logic [6:0] LD  = 7'b0000011, ST  = 7'b0100011, OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011, BR  = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111, LUI = 7'b0110111, AUI = 7'b0010111;
  localparam logic [6:0] SYS = 7'b1110011;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       opcode = '0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_sel_data, ir_en, opnd_en, alu_out_en;
  logic             mdr_en, rf_we, pc_en, instr_retired, halt;
  logic [1:0]       wb_sel, pc_src, halt_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel_data(mem_sel_data), .ir_en(ir_en), .opnd_en(opnd_en),
    .alu_out_en(alu_out_en), .mdr_en(mdr_en), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_en(pc_en), .pc_src(pc_src), .instr_retired(instr_retired), .halt(halt),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {mem_req, mem_we, mem_sel_data, ir_en, opnd_en, alu_out_en, mdr_en,
                rf_we, wb_sel, pc_en, pc_src, instr_retired, halt, halt_cause};

  typedef struct {
    logic [16:0] exp;
    logic        rdy;
    logic        bt;
    logic [6:0]  opc;
    string       tag;
  } step_t;

  step_t       plan[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;
  logic [6:0]  legal_ops[9] = '{LD, ST, OPR, OPI, BR, JAL, JLR, LUI, AUI};

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_opc();
    return 7'($urandom);
  endfunction

  // Required output vector; instr_retired must follow the retire (pc_en) cycle.
  function automatic logic [16:0] vec(input logic req, we, sel, ir, opnd, alu, mdr,
                                      rfwe, input logic [1:0] wbs, input logic pcen,
                                      input logic [1:0] pcs, input logic hlt,
                                      input logic [1:0] cause);
    return {req, we, sel, ir, opnd, alu, mdr, rfwe, wbs, pcen, pcs, pcen, hlt, cause};
  endfunction

  task automatic push(input logic [16:0] e, input logic r, input logic b,
                      input logic [6:0] o, input string t);
    step_t s;
    s.exp = e; s.rdy = r; s.bt = b; s.opc = o; s.tag = t;
    plan.push_back(s);
  endtask

  task automatic plan_halt(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++)
      push(vec(0,0,0,0,0,0,0,0,2'd0,0,2'd0,1,cause), rnd1(), rnd1(), rnd_opc(), "halt");
  endtask

  task automatic plan_instr(input logic [6:0] op, input logic taken,
                            input int fw, input int dw);
    logic is_ld, is_st, is_jmp, legal;
    is_ld  = (op == LD);
    is_st  = (op == ST);
    is_jmp = (op == JAL) || (op == JLR);
    legal  = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1'b1;
    for (int i = 0; i < fw; i++)
      push(vec(1,0,0,0,0,0,0,0,2'd0,0,2'd0,0,2'd0), 1'b0, rnd1(), rnd_opc(), "fetch_wait");
    push(vec(1,0,0,1,0,0,0,0,2'd0,0,2'd0,0,2'd0), 1'b1, rnd1(), rnd_opc(), "fetch");
    push(vec(0,0,0,0,1,0,0,0,2'd0,0,2'd0,0,2'd0), rnd1(), rnd1(), op, "decode");
    if (op == SYS) begin plan_halt(2'd1, 3); return; end
    if (!legal)    begin plan_halt(2'd2, 10); return; end
    if (op == BR) begin
      push(vec(0,0,0,0,0,1,0,0,2'd0,1,taken ? 2'd1 : 2'd0,0,2'd0), rnd1(), taken, op,
           "exec_branch");
      return;
    end
    push(vec(0,0,0,0,0,1,0,0,2'd0,0,2'd0,0,2'd0), rnd1(), rnd1(), op, "exec");
    if (is_ld || is_st) begin
      for (int i = 0; i < dw; i++)
        push(vec(1,is_st,1,0,0,0,0,0,2'd0,0,2'd0,0,2'd0), 1'b0, rnd1(), op, "mem_wait");
      if (is_st) begin
        push(vec(1,1,1,0,0,0,0,0,2'd0,1,2'd0,0,2'd0), 1'b1, rnd1(), op, "mem_store");
        return;
      end
      push(vec(1,0,1,0,0,0,1,0,2'd0,0,2'd0,0,2'd0), 1'b1, rnd1(), op, "mem_load");
    end
    push(vec(0,0,0,0,0,0,0,1, is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0), 1,
             is_jmp ? 2'd2 : 2'd0, 0, 2'd0), rnd1(), rnd1(), op, "wb");
  endtask

  task automatic check_counters();
    logic [CNT_W-1:0] ec, er;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ec = CNT_W'(exp_cyc);
    er = CNT_W'(exp_ret);
`else
    ec = '0;
    er = '0;
`endif
    vectors++;
    assert (cycle_cnt === ec) else begin
      miscompares++;
      $error("FAIL cycle_cnt cycle %0d: observed %0d expected %0d", cyc, cycle_cnt, ec);
    end
    vectors++;
    assert (instret_cnt === er) else begin
      miscompares++;
      $error("FAIL instret_cnt cycle %0d: observed %0d expected %0d", cyc, instret_cnt, er);
    end
  endtask

  // One planned cycle: drive after the rising edge, check on the falling edge.
  task automatic run_step();
    step_t s;
    s = plan.pop_front();
    mem_ready    = s.rdy;
    branch_taken = s.bt;
    opcode       = s.opc;
    @(negedge clk);
    cyc++;
    vectors++;
    assert (obs === s.exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %h expected %h", s.tag, cyc, obs, s.exp);
    end
    check_counters();
    if (!s.exp[2]) exp_cyc++;
    if (s.exp[3])  exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_all();
    while (plan.size() > 0) run_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = rnd1(); branch_taken = rnd1(); opcode = rnd_opc();
    @(negedge clk);
    exp_cyc = 0;
    exp_ret = 0;
    vectors++;
    assert (obs === 17'h0) else begin
      miscompares++;
      $error("FAIL reset_outputs: observed %h expected %h", obs, 17'h0);
    end
    check_counters();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // Directed: OP, LOAD with 2 data stalls, taken/not-taken branch, STORE, jumps.
    plan_instr(OPR, 1'b0, 0, 0);
    plan_instr(LD,  1'b0, 0, 2);
    plan_instr(BR,  1'b1, 0, 0);
    plan_instr(BR,  1'b0, 0, 0);
    plan_instr(ST,  1'b0, 1, 0);
    plan_instr(JAL, 1'b0, 0, 0);
    plan_instr(JLR, 1'b0, 2, 0);
    run_all();

    // Random legal mix with stalls below the timeout.
    for (int n = 0; n < 60; n++)
      plan_instr(legal_ops[$urandom_range(0, 8)], rnd1(),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    run_all();

    // Reset in the middle of a stalled data request.
    plan_instr(LD, 1'b0, 0, 3);
    for (int i = 0; i < 4; i++) run_step();
    mem_ready = 1'b0;
    #2;
    vectors++;
    assert (mem_req === 1'b1) else begin
      miscompares++;
      $error("FAIL mid_mem_req: observed %b expected %b", mem_req, 1'b1);
    end
    reset = 1'b1;
    #1;
    vectors++;
    assert (obs === 17'h0) else begin
      miscompares++;
      $error("FAIL async_reset_drop: observed %h expected %h", obs, 17'h0);
    end
    plan.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;

    // Three OPs then ECALL.
    plan_instr(OPR, 1'b0, 0, 0);
    plan_instr(OPI, 1'b0, 1, 0);
    plan_instr(OPR, 1'b0, 0, 0);
    plan_instr(SYS, 1'b0, 0, 0);
    run_all();

    // Illegal opcode.
    do_reset();
    plan_instr(7'b1111111, 1'b0, 0, 0);
    run_all();

    // Fetch never acknowledged: timeout after four stalled cycles.
    do_reset();
    for (int i = 0; i < 4; i++)
      push(vec(1,0,0,0,0,0,0,0,2'd0,0,2'd0,0,2'd0), 1'b0, rnd1(), rnd_opc(), "fetch_wait");
    plan_halt(2'd3, 5);
    run_all();

    // Data-phase timeout on a store.
    do_reset();
    plan_instr(ST, 1'b0, 0, 4);
    void'(plan.pop_back());
    plan_halt(2'd3, 3);
    run_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
